// File: rtl/ff_bank_pkg.sv
// Shared encodings for the arbitrated flip-flop bank: commands, FSM states and requester ids.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD   = 2'b00,
    CMD_CLEAR  = 2'b01,
    CMD_PRESET = 2'b10,
    CMD_NOP    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ff_cell_rst_pre_en.sv
// Single bank bit: synchronous clear, preset and enabled load, in that priority order.
module ff_cell_rst_pre_en (
  input  logic clk_i,
  input  logic clr_i,
  input  logic pre_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 1'b0;
    end else if (pre_i) begin
      q_d = 1'b1;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/ff_bank_arb_ctrl.sv
// Two-requester round-robin front end that applies masked LOAD/CLEAR/PRESET/NOP to a register bank.
module ff_bank_arb_ctrl
  import ff_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             a_valid_in,
  output logic             a_ready_out,
  input  logic [1:0]       a_cmd_in,
  input  logic [WIDTH-1:0] a_data_in,
  input  logic [WIDTH-1:0] a_mask_in,
  output logic             a_done_out,
  input  logic             b_valid_in,
  output logic             b_ready_out,
  input  logic [1:0]       b_cmd_in,
  input  logic [WIDTH-1:0] b_data_in,
  input  logic [WIDTH-1:0] b_mask_in,
  output logic             b_done_out,
  output logic [WIDTH-1:0] q_out,
  output logic             busy_out
);

  state_e           state_q, state_d;
  logic             last_q;
  cmd_e             cmd_q;
  logic [WIDTH-1:0] data_q, mask_q;
  logic             id_q;

  logic             grant_a, grant_b, accept;
  logic             exec_load, exec_clear, exec_preset;

  // Round-robin: on a tie the requester not granted last wins.
  assign grant_a = a_valid_in && (!b_valid_in || (last_q == REQ_B));
  assign grant_b = b_valid_in && (!a_valid_in || (last_q == REQ_A));
  assign accept  = a_ready_out || b_ready_out;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_ready_out = 1'b0;
    b_ready_out = 1'b0;
    if ((state_q == StIdle) && !reset_in) begin
      a_ready_out = grant_a;
      b_ready_out = grant_b;
    end
    busy_out    = (state_q == StExec) || (state_q == StResp);
    a_done_out  = (state_q == StResp) && (id_q == REQ_A) && !reset_in;
    b_done_out  = (state_q == StResp) && (id_q == REQ_B) && !reset_in;
    exec_load   = (state_q == StExec) && (cmd_q == CMD_LOAD);
    exec_clear  = (state_q == StExec) && (cmd_q == CMD_CLEAR);
    exec_preset = (state_q == StExec) && (cmd_q == CMD_PRESET);
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      last_q <= REQ_B;
      cmd_q  <= CMD_NOP;
      data_q <= '0;
      mask_q <= '0;
      id_q   <= REQ_A;
    end else if (accept) begin
      last_q <= b_ready_out ? REQ_B : REQ_A;
      id_q   <= b_ready_out ? REQ_B : REQ_A;
      cmd_q  <= b_ready_out ? cmd_e'(b_cmd_in) : cmd_e'(a_cmd_in);
      data_q <= b_ready_out ? b_data_in : a_data_in;
      mask_q <= b_ready_out ? b_mask_in : a_mask_in;
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    ff_cell_rst_pre_en u_cell (
      .clk_i (clk),
      .clr_i (reset_in || (exec_clear && mask_q[i])),
      .pre_i (exec_preset && mask_q[i]),
      .en_i  (exec_load && mask_q[i]),
      .d_i   (data_q[i]),
      .q_o   (q_out[i])
    );
  end

endmodule

// File: tb/tb_ff_bank_arb_ctrl.sv
// Directed bench for ff_bank_arb_ctrl with hand-computed expectations.
module tb_ff_bank_arb_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_in;
  logic         a_valid_in, b_valid_in;
  logic         a_ready_out, b_ready_out;
  logic [1:0]   a_cmd_in, b_cmd_in;
  logic [W-1:0] a_data_in, a_mask_in, b_data_in, b_mask_in;
  logic         a_done_out, b_done_out;
  logic [W-1:0] q_out;
  logic         busy_out;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ff_bank_arb_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_in    (reset_in),
    .a_valid_in  (a_valid_in),
    .a_ready_out (a_ready_out),
    .a_cmd_in    (a_cmd_in),
    .a_data_in   (a_data_in),
    .a_mask_in   (a_mask_in),
    .a_done_out  (a_done_out),
    .b_valid_in  (b_valid_in),
    .b_ready_out (b_ready_out),
    .b_cmd_in    (b_cmd_in),
    .b_data_in   (b_data_in),
    .b_mask_in   (b_mask_in),
    .b_done_out  (b_done_out),
    .q_out       (q_out),
    .busy_out    (busy_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_in   = 1'b1;
    a_valid_in = 1'b0;
    b_valid_in = 1'b0;
    tick();
    tick();
    reset_in = 1'b0;
  endtask

  // Full single-command transaction from an idle bank with only one requester valid.
  task automatic run_cmd(input string tag, input logic is_b, input logic [1:0] cmd,
                         input logic [W-1:0] data, input logic [W-1:0] mask,
                         input logic [W-1:0] q_before, input logic [W-1:0] q_after);
    if (is_b) begin
      b_valid_in = 1'b1; b_cmd_in = cmd; b_data_in = data; b_mask_in = mask;
    end else begin
      a_valid_in = 1'b1; a_cmd_in = cmd; a_data_in = data; a_mask_in = mask;
    end
    #1;
    check({tag, ".ready_a_T"}, a_ready_out, !is_b);
    check({tag, ".ready_b_T"}, b_ready_out, is_b);
    tick();
    a_valid_in = 1'b0; b_valid_in = 1'b0;
    a_data_in = ~data; b_data_in = ~data; a_mask_in = 8'hFF; b_mask_in = 8'hFF;
    a_cmd_in = 2'b10; b_cmd_in = 2'b10;
    check({tag, ".busy_T1"}, busy_out, 1'b1);
    check({tag, ".q_T1"}, q_out, q_before);
    check({tag, ".done_T1"}, {a_done_out, b_done_out}, 2'b00);
    tick();
    check({tag, ".q_T2"}, q_out, q_after);
    check({tag, ".done_T2"}, {a_done_out, b_done_out}, is_b ? 2'b01 : 2'b10);
    check({tag, ".busy_T2"}, busy_out, 1'b1);
    tick();
    check({tag, ".done_T3"}, {a_done_out, b_done_out}, 2'b00);
    check({tag, ".busy_T3"}, busy_out, 1'b0);
    check({tag, ".q_T3"}, q_out, q_after);
  endtask

  initial begin
    int acc_cyc[$];
    logic acc_id[$];
    a_cmd_in = 2'b11; b_cmd_in = 2'b11;
    a_data_in = '0; b_data_in = '0; a_mask_in = '0; b_mask_in = '0;

    // Reset with both valid high: readies must stay low.
    reset_in = 1'b1; a_valid_in = 1'b1; b_valid_in = 1'b1;
    tick();
    tick();
    check("rst.ready", {a_ready_out, b_ready_out}, 2'b00);
    check("rst.q", q_out, 8'h00);
    check("rst.busy", busy_out, 1'b0);
    check("rst.done", {a_done_out, b_done_out}, 2'b00);
    a_valid_in = 1'b0; b_valid_in = 1'b0;
    reset_in = 1'b0;

    run_cmd("a_load", 1'b0, 2'b00, 8'hA5, 8'hFF, 8'h00, 8'hA5);
    run_cmd("b_preset", 1'b1, 2'b10, 8'h00, 8'h0F, 8'hA5, 8'hAF);

    // Both valid every cycle from reset: A PRESET all, B NOP.
    do_reset();
    a_valid_in = 1'b1; a_cmd_in = 2'b10; a_data_in = 8'h00; a_mask_in = 8'hFF;
    b_valid_in = 1'b1; b_cmd_in = 2'b11; b_data_in = 8'h00; b_mask_in = 8'hFF;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (a_ready_out && b_ready_out) check("rr.both_ready", 1'b1, 1'b0);
      if (a_ready_out || b_ready_out) begin
        acc_cyc.push_back(c);
        acc_id.push_back(b_ready_out);
      end
      tick();
    end
    a_valid_in = 1'b0; b_valid_in = 1'b0;
    check("rr.count", acc_cyc.size(), 4);
    if (acc_cyc.size() == 4) begin
      check("rr.first_cyc", acc_cyc[0], 0);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr.grant%0d", k), acc_id[k], k % 2);
        if (k > 0) check($sformatf("rr.gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 3);
      end
    end
    check("rr.q", q_out, 8'hFF);
    check("rr.idle", busy_out, 1'b0);

    run_cmd("a_clear_nomask", 1'b0, 2'b01, 8'h00, 8'h00, 8'hFF, 8'hFF);
    run_cmd("b_clear_low", 1'b1, 2'b01, 8'h00, 8'h0F, 8'hFF, 8'hF0);
    run_cmd("a_nop", 1'b0, 2'b11, 8'h00, 8'hFF, 8'hF0, 8'hF0);

    // Reset during EXEC aborts the command.
    a_valid_in = 1'b1; a_cmd_in = 2'b00; a_data_in = 8'h3C; a_mask_in = 8'hFF;
    #1;
    check("abort.ready", a_ready_out, 1'b1);
    tick();
    a_valid_in = 1'b0;
    check("abort.busy_exec", busy_out, 1'b1);
    reset_in = 1'b1;
    #1;
    check("abort.ready_in_rst", {a_ready_out, b_ready_out}, 2'b00);
    tick();
    check("abort.q", q_out, 8'h00);
    check("abort.done", {a_done_out, b_done_out}, 2'b00);
    check("abort.busy", busy_out, 1'b0);
    reset_in = 1'b0;
    tick();
    check("abort.done_after", {a_done_out, b_done_out}, 2'b00);
    check("abort.q_after", q_out, 8'h00);

    // B waits while busy, then is accepted at T+3 exactly once.
    a_valid_in = 1'b1; a_cmd_in = 2'b00; a_data_in = 8'h55; a_mask_in = 8'hFF;
    b_valid_in = 1'b1; b_cmd_in = 2'b01; b_data_in = 8'h00; b_mask_in = 8'hF0;
    #1;
    check("hold.ready_T", {a_ready_out, b_ready_out}, 2'b10);
    tick();
    a_valid_in = 1'b0; a_data_in = 8'h00;
    #1;
    check("hold.ready_T1", b_ready_out, 1'b0);
    tick();
    check("hold.ready_T2", b_ready_out, 1'b0);
    check("hold.q_T2", q_out, 8'h55);
    check("hold.adone_T2", a_done_out, 1'b1);
    tick();
    check("hold.ready_T3", b_ready_out, 1'b1);
    check("hold.busy_T3", busy_out, 1'b0);
    tick();
    b_valid_in = 1'b0;
    check("hold.q_T4", q_out, 8'h55);
    tick();
    check("hold.q_T5", q_out, 8'h05);
    check("hold.done_T5", {a_done_out, b_done_out}, 2'b01);
    tick();
    check("hold.done_T6", {a_done_out, b_done_out}, 2'b00);
    tick();
    check("hold.done_T7", {a_done_out, b_done_out}, 2'b00);
    check("hold.busy_T7", busy_out, 1'b0);
    check("hold.q_T7", q_out, 8'h05);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
